// File: rtl/ddr3_pkg.sv
// rtl/ddr3_pkg.sv - command encodings, state type and defaults for the DDR3 read/write arbiter
package ddr3_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int unsigned DDR3_ADDR_STEP = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT
  } arb_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/ddr3_rw_arbiter.sv
// rtl/ddr3_rw_arbiter.sv - round-robin write/read burst arbiter in front of the MIG app interface
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int unsigned       BURST_LEN = 64,
  parameter int unsigned       ADDR_W    = 28,
  parameter logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(32'h0000_1000),
  parameter int unsigned       ADDR_STEP = DDR3_ADDR_STEP
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic [255:0]      wr_fifo_dout,
  output logic              wr_fifo_rd_en,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [255:0]      app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [255:0]      app_rd_data,
  input  logic              app_rd_data_valid,
  output logic [255:0]      rd_data,
  output logic              rd_data_valid,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W:0]  STEP_EXT = (ADDR_W + 1)'(ADDR_STEP);
  localparam logic [ADDR_W:0]  MAX_EXT  = {1'b0, ADDR_MAX};

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cmd_cnt_q, rd_cmd_cnt_d;
  logic [CNT_W-1:0]  rd_ret_cnt_q, rd_ret_cnt_d;
  logic [255:0]      rd_data_q;
  logic              rd_valid_q;

  // Extra top bit keeps the compare against ADDR_MAX safe when the step overflows ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] nxt;
    nxt = {1'b0, addr} + STEP_EXT;
    return (nxt >= MAX_EXT) ? '0 : nxt[ADDR_W-1:0];
  endfunction

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_RD;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_cnt_q     <= '0;
      rd_cmd_cnt_q <= '0;
      rd_ret_cnt_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cmd_cnt_q <= rd_cmd_cnt_d;
      rd_ret_cnt_q <= rd_ret_cnt_d;
      rd_data_q    <= app_rd_data;
      rd_valid_q   <= app_rd_data_valid;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cmd_cnt_d  = rd_cmd_cnt_q;
    rd_ret_cnt_d  = rd_ret_cnt_q;
    app_en        = 1'b0;
    app_cmd       = CMD_WR;
    app_addr      = '0;
    app_wdf_wren  = 1'b0;
    app_wdf_end   = 1'b0;
    wr_fifo_rd_en = 1'b0;

    // Read data may start returning while commands are still being issued.
    if ((state_q == ST_READ || state_q == ST_RD_WAIT) && app_rd_data_valid &&
        (rd_ret_cnt_q < CNT_FULL)) begin
      rd_ret_cnt_d = rd_ret_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (init_calib_complete && (wr_req || rd_req)) begin
          state_d      = ST_ARB;
          wr_cnt_d     = '0;
          rd_cmd_cnt_d = '0;
          rd_ret_cnt_d = '0;
        end
      end
      ST_ARB: begin
        if (wr_req && (!rd_req || last_grant_q == GRANT_RD)) state_d = ST_WRITE;
        else if (rd_req)                                     state_d = ST_READ;
        else                                                 state_d = ST_IDLE;
      end
      ST_WRITE: begin
        app_addr = wr_addr_q;
        if (app_rdy && app_wdf_rdy) begin
          app_en        = 1'b1;
          app_wdf_wren  = 1'b1;
          app_wdf_end   = 1'b1;
          wr_fifo_rd_en = 1'b1;
          wr_addr_d     = addr_next(wr_addr_q);
          wr_cnt_d      = wr_cnt_q + 1'b1;
          if (wr_cnt_q == CNT_LAST) begin
            state_d      = ST_IDLE;
            last_grant_d = GRANT_WR;
          end
        end
      end
      ST_READ: begin
        app_addr = rd_addr_q;
        app_cmd  = CMD_RD;
        app_en   = (rd_cmd_cnt_q < CNT_FULL);
        if (app_en && app_rdy) begin
          rd_addr_d    = addr_next(rd_addr_q);
          rd_cmd_cnt_d = rd_cmd_cnt_q + 1'b1;
          if (rd_cmd_cnt_q == CNT_LAST) state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rd_ret_cnt_d >= CNT_FULL) begin
          state_d      = ST_IDLE;
          last_grant_d = GRANT_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign app_wdf_data  = wr_fifo_dout;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb/tb_ddr3_rw_arbiter.sv - randomized self-checking bench for ddr3_rw_arbiter
module tb_ddr3_rw_arbiter;

  localparam int BL    = 4;
  localparam int STEP  = 8;
  localparam int AMAX  = 'h1000;
  localparam int WMAX  = 16;

  logic         ui_clk = 1'b0;
  logic         rst = 1'b1;
  logic         init_calib_complete = 1'b0;
  logic         wr_req = 1'b0;
  logic         rd_req = 1'b0;
  logic         app_rdy = 1'b0;
  logic         app_wdf_rdy = 1'b0;
  logic         app_rd_data_valid = 1'b0;
  logic [255:0] wr_fifo_dout = '0;
  logic [255:0] app_rd_data = '0;

  logic         wr_fifo_rd_en, app_en, app_wdf_wren, app_wdf_end, rd_data_valid, busy;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic [255:0] app_wdf_data, rd_data;

  logic         w_wr_fifo_rd_en, w_app_en, w_app_wdf_wren, w_app_wdf_end, w_rd_data_valid, w_busy;
  logic [27:0]  w_app_addr;
  logic [2:0]   w_app_cmd;
  logic [255:0] w_app_wdf_data, w_rd_data;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_ptr = 0;
  int w_wr_ptr = 0;
  int rd_ptr = 0;

  always #5 ui_clk = ~ui_clk;

  ddr3_rw_arbiter #(.BURST_LEN(BL), .ADDR_W(28), .ADDR_MAX(28'h000_1000), .ADDR_STEP(STEP)) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_fifo_dout(wr_fifo_dout), .wr_fifo_rd_en(wr_fifo_rd_en),
    .rd_req(rd_req), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy)
  );

  ddr3_rw_arbiter #(.BURST_LEN(BL), .ADDR_W(28), .ADDR_MAX(28'd16), .ADDR_STEP(STEP)) dut_wrap (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_fifo_dout(wr_fifo_dout), .wr_fifo_rd_en(w_wr_fifo_rd_en),
    .rd_req(rd_req), .app_addr(w_app_addr), .app_cmd(w_app_cmd), .app_en(w_app_en), .app_rdy(app_rdy),
    .app_wdf_data(w_app_wdf_data), .app_wdf_wren(w_app_wdf_wren), .app_wdf_end(w_app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rd_data(w_rd_data), .rd_data_valid(w_rd_data_valid), .busy(w_busy)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic reset_dut();
    @(negedge ui_clk);
    rst = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0; init_calib_complete = 1'b0;
    repeat (2) @(negedge ui_clk);
    rst = 1'b0;
    wr_ptr = 0; w_wr_ptr = 0; rd_ptr = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if ({app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=0000", {app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en}); end
    n_cmp++; if (rd_data_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL reset_rd_data got_valid=%b got_data=%h exp=0", rd_data_valid, rd_data); end
    n_cmp++; if (app_addr !== 28'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", app_addr); end
  endtask

  task automatic test_calib_gate();
    for (int k = 0; k < 4; k++) begin
      @(negedge ui_clk);
      init_calib_complete = 1'b0; wr_req = 1'b1; rd_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || app_en !== 1'b0) begin
        n_fail++; $display("FAIL calib_gate cyc=%0d got busy=%b en=%b exp 0/0", k, busy, app_en); end
    end
    @(negedge ui_clk);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  // mode 0: always ready, 1: app_wdf_rdy toggling, 2: random readies and calibration drops
  task automatic test_write_burst(input int mode);
    int beats, first_k, last_k;
    logic exp_en, exp_busy;
    bit idle_ok;
    beats = 0; first_k = -1; last_k = -1; idle_ok = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge ui_clk);
      init_calib_complete = (mode == 2 && k >= 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_req      = (k < 2);
      rd_req      = 1'b0;
      app_rdy     = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      app_wdf_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
      wr_fifo_dout = rand256();
      #1;
      exp_busy = (k >= 1) && (beats < BL);
      exp_en   = (k >= 2) && (beats < BL) && app_rdy && app_wdf_rdy;
      n_cmp++; if (busy !== exp_busy) begin
        n_fail++; $display("FAIL wr%0d_busy cyc=%0d got=%b exp=%b", mode, k, busy, exp_busy); end
      n_cmp++; if ({app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en} !== {4{exp_en}}) begin
        n_fail++; $display("FAIL wr%0d_strobes cyc=%0d got=%b exp=%b", mode, k,
                           {app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en}, {4{exp_en}}); end
      if (exp_en) begin
        n_cmp++; if (app_addr !== 28'(wr_ptr) || app_cmd !== 3'b000) begin
          n_fail++; $display("FAIL wr%0d_addr beat=%0d got=%h/%b exp=%h/000", mode, beats, app_addr, app_cmd, wr_ptr); end
        n_cmp++; if (w_app_addr !== 28'(w_wr_ptr)) begin
          n_fail++; $display("FAIL wr%0d_wrap_addr beat=%0d got=%h exp=%h", mode, beats, w_app_addr, w_wr_ptr); end
        n_cmp++; if (app_wdf_data !== wr_fifo_dout) begin
          n_fail++; $display("FAIL wr%0d_data beat=%0d got=%h exp=%h", mode, beats, app_wdf_data, wr_fifo_dout); end
        wr_ptr   = (wr_ptr + STEP) % AMAX;
        w_wr_ptr = (w_wr_ptr + STEP) % WMAX;
        if (first_k < 0) first_k = k;
        last_k = k;
        beats++;
      end
      if (beats == BL && !exp_busy) begin idle_ok = 1; break; end
    end
    n_cmp++; if (!idle_ok) begin n_fail++; $display("FAIL wr%0d_complete got beats=%0d exp=%0d then idle", mode, beats, BL); end
    if (mode == 0) begin
      n_cmp++; if (last_k - first_k != BL - 1) begin
        n_fail++; $display("FAIL wr0_span got=%0d exp=%0d", last_k - first_k, BL - 1); end
    end
    if (mode == 1) begin
      n_cmp++; if (last_k - first_k != 2 * (BL - 1)) begin
        n_fail++; $display("FAIL wr1_span got=%0d exp=%0d", last_k - first_k, 2 * (BL - 1)); end
    end
  endtask

  // mode 0: app_rdy held, data back 5 cycles after each command; 1: random app_rdy and latency
  task automatic test_read_burst(input int mode);
    int cmds, rets, last_ret, lat;
    int ret_cyc[$];
    logic [255:0] ret_dat[$];
    logic [255:0] prev_d;
    logic prev_v, exp_en, exp_busy;
    bit done;
    cmds = 0; rets = 0; last_ret = -1; done = 0;
    prev_v = app_rd_data_valid; prev_d = app_rd_data;
    for (int k = 0; k < 200; k++) begin
      @(negedge ui_clk);
      init_calib_complete = 1'b1; wr_req = 1'b0; rd_req = (k < 2); app_wdf_rdy = 1'b1;
      app_rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (ret_cyc.size() > 0 && ret_cyc[0] == k) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = ret_dat.pop_front();
        void'(ret_cyc.pop_front());
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = rand256();
      end
      #1;
      exp_busy = (k >= 1) && !done;
      exp_en   = (k >= 2) && (cmds < BL);
      n_cmp++; if (busy !== exp_busy) begin
        n_fail++; $display("FAIL rd%0d_busy cyc=%0d got=%b exp=%b", mode, k, busy, exp_busy); end
      n_cmp++; if (app_en !== exp_en || {app_wdf_wren, wr_fifo_rd_en} !== 2'b00) begin
        n_fail++; $display("FAIL rd%0d_en cyc=%0d got=%b/%b exp=%b/00", mode, k, app_en, {app_wdf_wren, wr_fifo_rd_en}, exp_en); end
      n_cmp++; if (rd_data_valid !== prev_v || rd_data !== prev_d) begin
        n_fail++; $display("FAIL rd%0d_fwd cyc=%0d got=%b/%h exp=%b/%h", mode, k, rd_data_valid, rd_data, prev_v, prev_d); end
      if (exp_en) begin
        n_cmp++; if (app_cmd !== 3'b001 || app_addr !== 28'(rd_ptr)) begin
          n_fail++; $display("FAIL rd%0d_cmd n=%0d got=%b/%h exp=001/%h", mode, cmds, app_cmd, app_addr, rd_ptr); end
        if (app_rdy) begin
          lat = (mode == 0) ? 5 : $urandom_range(1, 6);
          last_ret = (k + lat > last_ret + 1) ? k + lat : last_ret + 1;
          ret_cyc.push_back(last_ret);
          ret_dat.push_back(rand256());
          rd_ptr = (rd_ptr + STEP) % AMAX;
          cmds++;
        end
      end
      if (app_rd_data_valid && !done) rets++;
      prev_v = app_rd_data_valid; prev_d = app_rd_data;
      if (done && !exp_busy) break;
      if (rets == BL && cmds == BL) done = 1;
    end
    n_cmp++; if (!done || busy !== 1'b0) begin
      n_fail++; $display("FAIL rd%0d_complete got rets=%0d busy=%b exp=%0d/0", mode, rets, busy, BL); end
  endtask

  task automatic test_round_robin();
    int started, in_b;
    int ret_cyc[$];
    int rd_starts[$];
    bit last_is_rd, cur, idle_seen;
    reset_dut();
    last_is_rd = 1'b1; cur = 1'b0; started = 0; in_b = 0; idle_seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ui_clk);
      init_calib_complete = 1'b1; wr_req = (started < 4); rd_req = (started < 4);
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_fifo_dout = rand256(); app_rd_data = rand256();
      if (ret_cyc.size() > 0 && ret_cyc[0] == k) begin
        app_rd_data_valid = 1'b1; void'(ret_cyc.pop_front());
      end else app_rd_data_valid = 1'b0;
      #1;
      if (app_en && app_rdy) begin
        if (in_b == 0) begin
          cur = !last_is_rd;
          last_is_rd = cur;
          started++;
          if (cur) rd_starts.push_back(int'(app_addr));
        end
        n_cmp++; if (app_cmd !== {2'b00, cur}) begin
          n_fail++; $display("FAIL rr_order burst=%0d got cmd=%b exp=%b", started, app_cmd, {2'b00, cur}); end
        n_cmp++; if (app_addr !== 28'(cur ? rd_ptr : wr_ptr)) begin
          n_fail++; $display("FAIL rr_addr burst=%0d got=%h exp=%h", started, app_addr, cur ? rd_ptr : wr_ptr); end
        if (cur) begin
          rd_ptr = (rd_ptr + STEP) % AMAX;
          ret_cyc.push_back(k + 3);
        end else begin
          wr_ptr = (wr_ptr + STEP) % AMAX;
          w_wr_ptr = (w_wr_ptr + STEP) % WMAX;
        end
        in_b = (in_b + 1) % BL;
      end
      if (started == 4 && in_b == 0 && ret_cyc.size() == 0 && !busy) begin idle_seen = 1; break; end
    end
    n_cmp++; if (!idle_seen || started != 4) begin
      n_fail++; $display("FAIL rr_complete got bursts=%0d idle=%b exp=4/1", started, idle_seen); end
    n_cmp++; if (rd_starts.size() != 2) begin
      n_fail++; $display("FAIL rr_rd_count got=%0d exp=2", rd_starts.size());
    end else if (rd_starts[0] != 0 || rd_starts[1] != BL * STEP) begin
      n_fail++; $display("FAIL rr_rd_start got=%0d,%0d exp=0,%0d", rd_starts[0], rd_starts[1], BL * STEP);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 4; k++) begin
      @(negedge ui_clk);
      init_calib_complete = 1'b1; wr_req = (k < 2); rd_req = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      app_rd_data_valid = (k == 3); app_rd_data = rand256() | 256'd1;
      rst = (k == 3);
      #1;
      if (k == 3) begin
        n_cmp++; if (app_en !== 1'b1 || app_addr !== 28'(wr_ptr + STEP)) begin
          n_fail++; $display("FAIL rst_second_beat got en=%b addr=%h exp=1/%h", app_en, app_addr, wr_ptr + STEP); end
      end
    end
    @(negedge ui_clk);
    rst = 1'b0; wr_req = 1'b0; app_rd_data_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || {app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en} !== 4'b0) begin
      n_fail++; $display("FAIL rst_abort got busy=%b strobes=%b exp=0/0000", busy, {app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en}); end
    n_cmp++; if (rd_data_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL rst_rd_data got=%b/%h exp=0/0", rd_data_valid, rd_data); end
    wr_ptr = 0; w_wr_ptr = 0; rd_ptr = 0;
    test_write_burst(0);
  endtask

  initial begin
    reset_dut();
    test_reset();
    test_calib_gate();
    test_write_burst(0);
    test_write_burst(1);
    test_write_burst(2);
    test_read_burst(0);
    test_read_burst(1);
    test_round_robin();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_rw_arbiter.md
DDR3_RW_ARBITER -- requirements
Module: ddr3_rw_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, 64, number of 256-bit beats per write or read burst (range 1..256).
REQ-002 SHALL have parameter ADDR_W, 28, width of the MIG app_addr.
REQ-003 SHALL have parameter ADDR_MAX, 28'h000_1000, exclusive upper bound of the test region; pointers wrap to 0 on reaching it.
REQ-004 SHALL have parameter ADDR_STEP, 8, address increment per beat (BL8).
REQ-005 ui_clk  in  1  clock for all logic.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 init_calib_complete  in  1  MIG calibration done.
REQ-008 wr_req  in  1  write FIFO holds >= BURST_LEN words.
REQ-009 wr_fifo_dout  in  256  first-word-fall-through write FIFO head.
REQ-010 wr_fifo_rd_en  out  1  pop write FIFO.
REQ-011 rd_req  in  1  request one read burst.
REQ-012 app_addr  out  ADDR_W  MIG command address.
REQ-013 app_cmd  out  3  000 write, 001 read.
REQ-014 app_en  out  1  command valid.
REQ-015 app_rdy  in  1  MIG accepts command.
REQ-016 app_wdf_data  out  256  write data.
REQ-017 app_wdf_wren / app_wdf_end  out  1 each  write data valid / last word of beat.
REQ-018 app_wdf_rdy  in  1  MIG accepts write data.
REQ-019 app_rd_data  in  256; app_rd_data_valid  in  1  read return.
REQ-020 rd_data / rd_data_valid  out  256 / 1  read data forwarded to the user.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ARB, WRITE, READ, RD_WAIT.
REQ-023 IDLE -> ARB when init_calib_complete=1 and (wr_req or rd_req); otherwise stay in IDLE.
REQ-024 ARB SHALL grant round-robin on a last_grant flag: if both requests are high, serve the opposite of last_grant; if only one is high, serve it; ARB -> WRITE or READ in 1 cycle.
REQ-025 WRITE: a beat SHALL complete only in a cycle with app_rdy=1 and app_wdf_rdy=1; in that cycle app_en=app_wdf_wren=app_wdf_end=wr_fifo_rd_en=1, app_cmd=000, and app_wdf_data=wr_fifo_dout (combinational).
REQ-026 In WRITE, app_en and app_wdf_wren SHALL be driven only when both ready signals are high, so command and data never split.
REQ-027 READ: app_en=1 and app_cmd=001 while the issued-command count < BURST_LEN; a command counts when app_rdy=1.
REQ-028 READ -> RD_WAIT after BURST_LEN commands; RD_WAIT -> IDLE when the returned-beat count reaches BURST_LEN.
REQ-029 The returned-beat counter SHALL increment on every app_rd_data_valid, including cycles still in READ.
REQ-030 rd_data/rd_data_valid SHALL register app_rd_data/app_rd_data_valid with 1-cycle latency.
REQ-031 WRITE -> IDLE on the cycle the BURST_LEN-th beat completes; last_grant updates on burst completion.
REQ-032 Separate wr_addr and rd_addr pointers SHALL advance by ADDR_STEP per accepted command and wrap to 0 when the next value is >= ADDR_MAX.
REQ-033 app_addr SHALL equal wr_addr in WRITE, rd_addr in READ, and 0 otherwise.
REQ-034 A deassertion of init_calib_complete mid-burst SHALL be ignored until the burst ends.
REQ-035 Beat counters SHALL be $clog2(BURST_LEN)+1 bits wide and SHALL clear on entry to ARB.

Reset
REQ-036 On rst: state=IDLE, wr_addr=rd_addr=0, counters=0, last_grant=read (so the first tie goes to write), and rd_data=0 with rd_data_valid=0.
REQ-037 rst asserted mid-burst SHALL abort immediately and drive all app_* strobes and wr_fifo_rd_en low in the following cycle.

Structure
REQ-038 Package ddr3_pkg SHALL hold the CMD_WR/CMD_RD encodings, the FSM state enumeration, and the ADDR_STEP default.
REQ-039 The block SHALL be a single module with no sub-module.

Verification
REQ-040 BURST_LEN=4, wr_req=1, app_rdy=app_wdf_rdy=1 -> 4 consecutive beats at app_addr 0,8,16,24; wr_fifo_rd_en high for exactly 4 cycles; back to IDLE.
REQ-041 wr_req and rd_req held high together -> order W,R,W,R; rd_addr advances 0,32 after two read bursts.
REQ-042 app_wdf_rdy toggling 1,0,1,0 during WRITE -> no app_en or wr_fifo_rd_en in the low cycles; 4 beats take 8 cycles.
REQ-043 ADDR_MAX=16, BURST_LEN=4, one write burst -> app_addr sequence 0,8,0,8.
REQ-044 Read burst with app_rd_data_valid returning 4 beats 5 cycles late -> RD_WAIT holds until the 4th beat; rd_data_valid lags each beat by 1 cycle.
REQ-045 rst pulsed on the 2nd write beat -> IDLE next cycle, strobes low, next burst starts at addr 0.
